// File: rtl/ahb2apb_apbm_swc.sv
// APB3 master stage of the AHB-to-APB bridge: one SETUP/ACCESS transfer per request pulse.
// Define AHB2APB_APBM_TIMEOUT_EN to enable the ACCESS-phase watchdog (TIMEOUT_CYCLES).
module ahb2apb_apbm_swc #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              hclk,
    input  logic              hrstn,
    input  logic              wreq,
    input  logic [ADDR_W-1:0] wbuffaddr,
    input  logic [DATA_W-1:0] wbuffdata,
    input  logic              rreq,
    input  logic [ADDR_W-1:0] rbuffaddr,
    output logic [DATA_W-1:0] rbuffdata,
    output logic              done,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              psel_q, psel_d, penable_q, penable_d;
    logic              pwrite_q, pwrite_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic              accept, expire;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // DONE accepts requests exactly like IDLE so back-to-back transfers have no gap
    assign accept = ((state_q == IDLE) || (state_q == DONE)) && (wreq || rreq);

`ifdef AHB2APB_APBM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP)
            cnt_d = '0;
        else if ((state_q == ACCESS) && !pready)
            cnt_d = cnt_q + 1'b1;
    end

    // Expiry fires on the TIMEOUT_CYCLES-th stalled ACCESS cycle; pready in that cycle still wins
    assign expire = (state_q == ACCESS) && !pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            done_q    <= done_d;
            err_q     <= err_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? SETUP : IDLE;
            SETUP:      state_d = ACCESS;
            ACCESS:     state_d = (pready || expire) ? DONE : ACCESS;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs are registered, so their next values are decoded from the next state
    always_comb begin
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        done_d    = (state_d == DONE);
        pwrite_d  = pwrite_q;
        err_d     = err_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        if (accept) begin
            err_d = 1'b0;
            if (wreq) begin
                paddr_d  = wbuffaddr;
                pwdata_d = wbuffdata;
                pwrite_d = 1'b1;
            end else begin
                paddr_d  = rbuffaddr;
                pwrite_d = 1'b0;
            end
        end else if ((state_q == ACCESS) && pready) begin
            err_d = pslverr;
            if (!pwrite_q) rdata_d = prdata;
        end else if (expire) begin
            err_d = 1'b1;
            if (!pwrite_q) rdata_d = '0;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign done      = done_q;
    assign err       = err_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rbuffdata = rdata_q;

endmodule

// File: tb/tb_ahb2apb_apbm_swc.sv
// Randomized bench for ahb2apb_apbm_swc against a transaction-level reference model.
module tb_ahb2apb_apbm_swc;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          hclk = 1'b0;
    logic          hrstn = 1'b0;
    logic          wreq = 1'b0, rreq = 1'b0;
    logic [AW-1:0] wbuffaddr = '0, rbuffaddr = '0;
    logic [DW-1:0] wbuffdata = '0, prdata = '0;
    logic          pready = 1'b0, pslverr = 1'b0;
    logic [DW-1:0] rbuffdata, pwdata;
    logic [AW-1:0] paddr;
    logic          done, err, psel, penable, pwrite;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: architectural values visible between transfers
    logic [DW-1:0] exp_rdata = '0, exp_pwdata = '0;
    logic [AW-1:0] exp_paddr = '0;
    logic          exp_err = 1'b0, exp_pwrite = 1'b0;

    ahb2apb_apbm_swc #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .hclk(hclk), .hrstn(hrstn),
        .wreq(wreq), .wbuffaddr(wbuffaddr), .wbuffdata(wbuffdata),
        .rreq(rreq), .rbuffaddr(rbuffaddr), .rbuffdata(rbuffdata),
        .done(done), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 hclk = ~hclk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_paddr"}, paddr, exp_paddr);
        check({tag, "_pwdata"}, pwdata, exp_pwdata);
        check({tag, "_pwrite"}, pwrite, exp_pwrite);
        check({tag, "_rbuffdata"}, rbuffdata, exp_rdata);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_psel"}, psel, 1'b0);
        check({tag, "_penable"}, penable, 1'b0);
        check({tag, "_err"}, err, exp_err);
        check_regs(tag);
    endtask

    // Present a request at a negedge (state IDLE or DONE) and scramble the buffers afterwards
    task automatic request(input bit wr, input bit both, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wreq = wr | both;
        rreq = ~wr | both;
        wbuffaddr = a;
        wbuffdata = d;
        rbuffaddr = both ? (a ^ 32'hFFFF_0000) : a;
        step();
        wreq = 1'b0;
        rreq = 1'b0;
        wbuffaddr = $urandom;
        wbuffdata = $urandom;
        rbuffaddr = $urandom;
        exp_paddr = a;
        exp_pwrite = wr | both;
        if (wr | both) exp_pwdata = d;
        exp_err = 1'b0;
    endtask

    // One complete transfer: latency must be exactly 3 + waits cycles
    task automatic xfer(input bit wr, input bit both, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input bit slverr, input logic [DW-1:0] rd, input bit poke);
        request(wr, both, a, d);
        check("setup_psel", psel, 1'b1);
        check("setup_penable", penable, 1'b0);
        check("setup_done", done, 1'b0);
        check("setup_err", err, 1'b0);
        check_regs("setup");
        step();
        for (int i = 0; i <= waits; i++) begin
            check("access_psel", psel, 1'b1);
            check("access_penable", penable, 1'b1);
            check("access_done", done, 1'b0);
            check_regs("access");
            rreq = poke && (i == 0);
            rbuffaddr = $urandom;
            pready = (i == waits);
            prdata = (i == waits) ? rd : DW'($urandom);
            pslverr = (i == waits) ? slverr : 1'($urandom);
            step();
        end
        rreq = 1'b0;
        pready = 1'b0;
        pslverr = 1'b0;
        prdata = $urandom;
        exp_err = slverr;
        if (!(wr | both)) exp_rdata = rd;
        check("done_done", done, 1'b1);
        check("done_err", err, exp_err);
        check("done_psel", psel, 1'b0);
        check("done_penable", penable, 1'b0);
        check_regs("done");
    endtask

    initial begin
        @(negedge hclk);
        check("rst_done", done, 1'b0);
        check("rst_psel", psel, 1'b0);
        check("rst_err", err, 1'b0);
        check_regs("rst");
        hrstn = 1'b1;
        step();
        check_idle("post_rst");

        xfer(1'b1, 1'b0, 32'h4000_0010, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 1'b0);
        step();
        check_idle("wr_idle");

        xfer(1'b0, 1'b0, 32'h4000_0020, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0);
        step();
        check_idle("rd_idle");
        xfer(1'b1, 1'b0, 32'h4000_0030, 32'h5555_AAAA, 1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        step();
        check_idle("rd_hold");

        xfer(1'b1, 1'b0, 32'h4000_0040, 32'h0BAD_0BAD, 2, 1'b1, 32'h0, 1'b0);
        step();
        check_idle("slverr_idle");
        xfer(1'b0, 1'b0, 32'h4000_0044, 32'h0, 0, 1'b0, 32'h8765_4321, 1'b0);
        step();
        check_idle("err_clear");

        xfer(1'b0, 1'b1, 32'h4000_0050, 32'h1111_2222, 2, 1'b0, 32'h0, 1'b1);
        step();
        check_idle("both_idle");
        step();
        check_idle("both_idle2");

        for (int n = 0; n < 60; n++) begin
            xfer(1'($urandom), ($urandom_range(0, 7) == 0), $urandom, $urandom,
                 $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                step();
                check_idle("rand_idle");
            end
        end
        step();
        check_idle("rand_end");

        // Asynchronous reset while in ACCESS
        request(1'b0, 1'b0, 32'h4000_0060, 32'h0);
        step();
        check("mid_access_penable", penable, 1'b1);
        #1 hrstn = 1'b0;
        #1;
        exp_rdata = '0; exp_pwdata = '0; exp_paddr = '0; exp_err = 1'b0; exp_pwrite = 1'b0;
        check("async_rst_psel", psel, 1'b0);
        check("async_rst_penable", penable, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_err", err, 1'b0);
        check_regs("async_rst");
        step();
        hrstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("after_rst");
        end

        request(1'b0, 1'b0, 32'h4000_0070, 32'h0);
        step();
`ifdef AHB2APB_APBM_TIMEOUT_EN
        begin
            int acc = 0;
            int guard = 0;
            while (!done && guard < 100) begin
                if (psel && penable) acc++;
                guard++;
                step();
            end
            exp_err = 1'b1;
            exp_rdata = '0;
            check("to_done", done, 1'b1);
            check("to_access_cycles", acc, TO);
            check("to_err", err, 1'b1);
            check("to_psel", psel, 1'b0);
            check_regs("to");
        end
`else
        for (int i = 0; i < 100; i++) step();
        check("stall_psel", psel, 1'b1);
        check("stall_penable", penable, 1'b1);
        check("stall_done", done, 1'b0);
        pready = 1'b1;
        prdata = 32'hA5A5_5A5A;
        step();
        pready = 1'b0;
        exp_rdata = 32'hA5A5_5A5A;
        exp_err = 1'b0;
        check("stall_release_done", done, 1'b1);
        check_regs("stall_release");
`endif
        step();
        check_idle("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
